// File: rtl/mod_arith_pkg.sv
// mod_arith_pkg: declarations shared by the modular arithmetic stages.
//   state_t           - sequencer states (IDLE, RUN, DONE)
//   BITWIDTH_DEFAULT  - default operand/modulus width
//   MAX_W             - widest operand the cond_sub helper supports
//   cond_sub(x, q)    - single conditional subtract: x >= q ? x - q : x.
//                       x is one bit wider than q so that 2*acc and acc + A
//                       can be reduced without losing the carry.
package mod_arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned BITWIDTH_DEFAULT = 16;
    localparam int unsigned MAX_W            = 64;

    function automatic logic [MAX_W-1:0] cond_sub(input logic [MAX_W:0]   x,
                                                  input logic [MAX_W-1:0] q);
        logic [MAX_W:0] qx;
        logic [MAX_W:0] diff;
        qx   = {1'b0, q};
        diff = x - qx;
        return (x >= qx) ? diff[MAX_W-1:0] : x[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/mod_dbl_add_step.sv
// mod_dbl_add_step: one combinational iteration of MSB-first interleaved
// modular multiplication.
//   acc_in  in  W  running accumulator (< q)
//   a       in  W  multiplicand (< q)
//   q       in  W  modulus
//   b_bit   in  1  current multiplier bit
//   acc_out out W  ((2*acc_in mod q) + b_bit*a) mod q
module mod_dbl_add_step
    import mod_arith_pkg::*;
#(
    parameter int unsigned W = BITWIDTH_DEFAULT
) (
    input  logic [W-1:0] acc_in,
    input  logic [W-1:0] a,
    input  logic [W-1:0] q,
    input  logic         b_bit,
    output logic [W-1:0] acc_out
);

    localparam int unsigned XW = MAX_W + 1;

    logic [W:0]   dbl;
    logic [W-1:0] dbl_red;
    logic [W:0]   sum;
    logic [W-1:0] sum_red;

    always_comb begin
        dbl     = {acc_in, 1'b0};
        dbl_red = W'(cond_sub(XW'(dbl), MAX_W'(q)));
        sum     = {1'b0, dbl_red} + {1'b0, a};
        sum_red = W'(cond_sub(XW'(sum), MAX_W'(q)));
        acc_out = b_bit ? sum_red : dbl_red;
    end

endmodule

// File: rtl/mod_mul_seq.sv
// mod_mul_seq: sequential modular multiplier, oData = (iA * iB) mod iQ,
// MSB-first interleaved shift-and-add with conditional subtraction.
// Optional macro MOD_MUL_SEQ_RADIX4_EN: two multiplier bits per RUN cycle
// (BITWIDTH must then be even); results are identical in both modes.
//   iClk    in   1         clock, rising edge
//   iRstN   in   1         asynchronous active-low reset
//   iClr    in   1         synchronous abort to IDLE, clears outputs
//   iValid  in   1         operands valid
//   oReady  out  1         operands accepted (high only in IDLE)
//   iA      in   BITWIDTH  multiplicand (< iQ)
//   iB      in   BITWIDTH  multiplier (< iQ)
//   iQ      in   BITWIDTH  modulus (>= 2)
//   oValid  out  1         oData holds a result (DONE)
//   iReady  in   1         downstream accepts result
//   oData   out  BITWIDTH  product mod Q
module mod_mul_seq
    import mod_arith_pkg::*;
#(
    parameter int unsigned BITWIDTH = BITWIDTH_DEFAULT
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iClr,
    input  logic                iValid,
    output logic                oReady,
    input  logic [BITWIDTH-1:0] iA,
    input  logic [BITWIDTH-1:0] iB,
    input  logic [BITWIDTH-1:0] iQ,
    output logic                oValid,
    input  logic                iReady,
    output logic [BITWIDTH-1:0] oData
);

    localparam int unsigned CW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

`ifdef MOD_MUL_SEQ_RADIX4_EN
    localparam int unsigned STEP = 2;
`else
    localparam int unsigned STEP = 1;
`endif

    state_t              state;
    state_t              state_n;
    logic [BITWIDTH-1:0] a_r;
    logic [BITWIDTH-1:0] b_r;
    logic [BITWIDTH-1:0] q_r;
    logic [BITWIDTH-1:0] acc;
    logic [BITWIDTH-1:0] data_r;
    logic [CW-1:0]       cnt;
    logic [BITWIDTH-1:0] step0_out;
    logic [BITWIDTH-1:0] step_out;
    logic                last;

    mod_dbl_add_step #(.W(BITWIDTH)) u_step0 (
        .acc_in  (acc),
        .a       (a_r),
        .q       (q_r),
        .b_bit   (b_r[cnt]),
        .acc_out (step0_out)
    );

`ifdef MOD_MUL_SEQ_RADIX4_EN
    logic [CW-1:0] cnt_m1;
    assign cnt_m1 = cnt - CW'(1);

    // Second iteration consumes the next lower multiplier bit in the same cycle.
    mod_dbl_add_step #(.W(BITWIDTH)) u_step1 (
        .acc_in  (step0_out),
        .a       (a_r),
        .q       (q_r),
        .b_bit   (b_r[cnt_m1]),
        .acc_out (step_out)
    );
    assign last = (cnt == CW'(1));
`else
    assign step_out = step0_out;
    assign last     = (cnt == '0);
`endif

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (iValid) state_n = RUN;
            RUN:     if (last)   state_n = DONE;
            DONE:    if (iReady) state_n = IDLE;
            default:             state_n = IDLE;
        endcase
        if (iClr) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            a_r    <= '0;
            b_r    <= '0;
            q_r    <= '0;
            acc    <= '0;
            data_r <= '0;
            cnt    <= '0;
        end else if (iClr) begin
            acc    <= '0;
            data_r <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (iValid) begin
                        a_r <= iA;
                        b_r <= iB;
                        q_r <= iQ;
                        acc <= '0;
                        cnt <= CW'(BITWIDTH - 1);
                    end
                end
                RUN: begin
                    acc <= step_out;
                    cnt <= cnt - CW'(STEP);
                    if (last) begin
                        data_r <= step_out;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oReady = (state == IDLE);
    assign oValid = (state == DONE);
    assign oData  = data_r;

endmodule

// File: tb/tb_mod_mul_seq.sv
module tb_mod_mul_seq;

    localparam int unsigned W = 16;
`ifdef MOD_MUL_SEQ_RADIX4_EN
    localparam int unsigned LAT = W / 2;
`else
    localparam int unsigned LAT = W;
`endif

    logic         iClk = 1'b0;
    logic         iRstN = 1'b0;
    logic         iClr = 1'b0;
    logic         iValid = 1'b0;
    logic         oReady;
    logic [W-1:0] iA = '0;
    logic [W-1:0] iB = '0;
    logic [W-1:0] iQ = '0;
    logic         oValid;
    logic         iReady = 1'b0;
    logic [W-1:0] oData;

    int checks = 0;
    int errors = 0;

    mod_mul_seq #(.BITWIDTH(W)) dut (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iClr   (iClr),
        .iValid (iValid),
        .oReady (oReady),
        .iA     (iA),
        .iB     (iB),
        .iQ     (iQ),
        .oValid (oValid),
        .iReady (iReady),
        .oData  (oData)
    );

    always #5 iClk = ~iClk;

    function automatic int unsigned ref_mulmod(int unsigned a, int unsigned b, int unsigned q);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return int'(p % longint'(q));
    endfunction

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Present operands for exactly one edge; block must be idle.
    task automatic start(input int unsigned a, input int unsigned b, input int unsigned q);
        chk("ready_before_accept", oReady, 1);
        iA = W'(a); iB = W'(b); iQ = W'(q);
        iValid = 1'b1;
        tick();
        iValid = 1'b0;
        chk("ready_low_in_run", oReady, 0);
    endtask

    task automatic wait_result(input string tag, input int unsigned exp);
        int n = 0;
        while (!oValid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, LAT);
        chk({tag, "_data"}, oData, exp);
    endtask

    task automatic release_result();
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        chk("valid_low_after_handshake", oValid, 0);
        chk("ready_after_handshake", oReady, 1);
    endtask

    task automatic full_op(input string tag, input int unsigned a, input int unsigned b,
                           input int unsigned q);
        start(a, b, q);
        wait_result(tag, ref_mulmod(a, b, q));
        release_result();
    endtask

    initial begin
        int unsigned held;
        int unsigned q, a, b;

        // Reset values
        #2;
        chk("rst_ready", oReady, 1);
        chk("rst_valid", oValid, 0);
        chk("rst_data", oData, 0);
        #10;
        iRstN = 1'b1;
        tick();

        // Directed cases
        full_op("q17_5x7", 5, 7, 17);
        chk("q17_5x7_const", oData, 1);
        full_op("q65521_max", 65520, 65520, 65521);
        chk("q65521_const", oData, 1);
        full_op("q97_a0", 0, 55, 97);
        full_op("q97_b0", 44, 0, 97);

        // Back-to-back: handshake edge then accept edge, BITWIDTH+2 spacing
        start(3, 4, 97);
        wait_result("b2b_first", 12);
        iReady = 1'b1;
        iA = 16'd96; iB = 16'd96; iQ = 16'd97;
        iValid = 1'b1;
        tick();
        chk("b2b_handshake_idle", oReady, 1);
        chk("b2b_handshake_novalid", oValid, 0);
        tick();
        iValid = 1'b0;
        iReady = 1'b0;
        chk("b2b_accepted", oReady, 0);
        wait_result("b2b_second", 1);
        release_result();

        // Backpressure with input churn
        start(11, 13, 17);
        wait_result("bp", ref_mulmod(11, 13, 17));
        held = oData;
        for (int i = 0; i < 10; i++) begin
            iA = W'($urandom); iB = W'($urandom); iQ = W'($urandom);
            iValid = 1'b1;
            tick();
            chk("bp_data_stable", oData, held);
            chk("bp_valid_held", oValid, 1);
            chk("bp_ready_low", oReady, 0);
        end
        iValid = 1'b0;
        release_result();
        full_op("after_bp", 9, 10, 23);

        // Synchronous abort during RUN
        start(100, 200, 251);
        for (int i = 0; i < 4; i++) tick();
        iClr = 1'b1;
        tick();
        iClr = 1'b0;
        chk("clr_ready", oReady, 1);
        chk("clr_valid", oValid, 0);
        chk("clr_data", oData, 0);
        // Abort and accept on the same edge: nothing captured
        iClr = 1'b1; iValid = 1'b1;
        iA = 16'd1; iB = 16'd1; iQ = 16'd3;
        tick();
        iClr = 1'b0; iValid = 1'b0;
        chk("clr_vs_accept_ready", oReady, 1);
        full_op("after_clr", 6, 9, 13);
        chk("after_clr_const", oData, 2);

        // Asynchronous reset mid-RUN, with a stale nonzero result in oData
        start(7, 8, 17);
        tick(); tick();
        #2;
        iRstN = 1'b0;
        #1;
        chk("arst_ready", oReady, 1);
        chk("arst_valid", oValid, 0);
        chk("arst_data", oData, 0);
        @(negedge iClk);
        iRstN = 1'b1;
        tick();
        full_op("after_rst", 16, 16, 17);

        // Random operands against the arithmetic reference
        for (int i = 0; i < 25; i++) begin
            q = $urandom_range(65535, 2);
            a = $urandom_range(q - 1, 0);
            b = $urandom_range(q - 1, 0);
            full_op("rand", a, b, q);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_mul_seq.md
# mod_mul_seq

Sequential modular multiplier that computes oData = (iA × iB) mod iQ by MSB-first interleaved shift-and-add with conditional subtraction. It processes one multiplier bit per cycle, or two with the radix-4 option. It sits directly upstream of the registered modular adder stage and supplies one operand to it, for example for multiply-accumulate in NTT butterflies. Operands use ready/valid handshakes on both sides.

## Interface
- BITWIDTH, 16, operand/modulus width; must be even when MOD_MUL_SEQ_RADIX4_EN is defined
- iClk  in  1  clock, rising edge
- iRstN  in  1  reset, asynchronous, active-low
- iClr  in  1  synchronous abort; returns to IDLE, clears outputs
- iValid  in  1  input operands valid
- oReady  out  1  block can accept operands (high only in IDLE)
- iA  in  BITWIDTH  multiplicand, must be < iQ
- iB  in  BITWIDTH  multiplier, must be < iQ
- iQ  in  BITWIDTH  modulus, must be ≥ 2
- oValid  out  1  oData holds a result
- iReady  in  1  downstream accepts result
- oData  out  BITWIDTH  product mod Q

## Operation
- States:
  - IDLE: oReady=1. On iValid&&oReady, capture A, B and Q into registers, set acc=0 and cnt=BITWIDTH-1, then go to RUN.
  - RUN: each cycle, acc ← (2·acc mod Q); if B[cnt], acc ← (acc + A) mod Q. Then cnt decrements.
    - When cnt==0, the step is applied, oData ← result, oValid ← 1, and the state goes to DONE.
  - DONE: oValid=1, oData stable. On iReady, oValid ← 0 and the state goes to IDLE.
- Width rules: 2·acc and acc+A are formed in BITWIDTH+1 bits. Each is reduced by a single conditional subtract: if x ≥ Q then x−Q.
  - Invariant: acc < Q at every step.
- Inputs ≥ Q: the result is undefined. There is no checking.
- Input ports are sampled only at the accept edge. Changes to iA, iB or iQ during RUN or DONE have no effect.
- iClr has priority over all other activity in every state. It forces IDLE and sets oValid=0, oData=0 and acc=0.
- iValid in RUN or DONE is ignored; oReady=0 there.

## Timing
- Reset values: oValid=0, oReady=1 (IDLE), oData=0, acc=0, cnt=0.
- Latency: oValid rises exactly BITWIDTH cycles after the accept edge, i.e. 16 cycles at the default width.
- Throughput: one result per BITWIDTH+2 cycles when iReady is held high. Cycles are spent as follows:
  - accept
  - BITWIDTH RUN steps
  - a DONE handshake edge
  - an IDLE accept edge
- Backpressure: DONE persists indefinitely while iReady=0, and oData stays unchanged.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). The in-flight result is lost.
- iClr and the iValid accept on the same edge: iClr wins and nothing is captured.
- oReady and oValid are registered-state decodes, with no combinational path from iValid or iReady.

## Configuration
- MOD_MUL_SEQ_RADIX4_EN:
  - Defined: two chained double/add/reduce steps per RUN cycle, consuming B[cnt] then B[cnt-1]. cnt starts at BITWIDTH-1 and decrements by 2. The final step is at cnt==1. Latency is BITWIDTH/2 cycles.
  - Undefined: one bit per cycle as above.
- Results are identical in both modes.

## Structure
- Shared package mod_arith_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - the BITWIDTH default constant
  - the cond_sub reduction helper function, shared with the adder stage
- Sub-module mod_dbl_add_step: a combinational single iteration (acc, A, Q, bit) → acc'.
  - Instantiated once normally.
  - Instantiated twice, chained, under MOD_MUL_SEQ_RADIX4_EN.

## Test plan
- Q=17, A=5, B=7, iReady=1 → oData=1; oValid rises 16 cycles after accept (8 cycles with RADIX4).
- Q=65521, A=65520, B=65520 → oData=1. This exercises a reduction on every step and the BITWIDTH+1 intermediates.
- Q=97, A=0 or B=0 → oData=0. Then a back-to-back pair (A=3, B=4 → 12; A=96, B=96 → 1) checks the BITWIDTH+2 cycle spacing.
- Hold iReady=0 for 10 cycles after oValid, toggling iA/iB/iQ meanwhile → oData stable and oReady=0 throughout; release, and the next accept completes normally.
- Assert iClr at RUN cycle 5 → next cycle IDLE, oValid=0, oData=0, oReady=1. A new operation (Q=13, A=6, B=9) → 2.
- Drop iRstN asynchronously mid-RUN → outputs go to reset values without a clock edge. After release, Q=17, A=16, B=16 → 1.
